avmm_slave_mem: RTL and testbench

AVMM_SLAVE_MEM -- requirements
Module: avmm_slave_mem

---
 rtl/avmm_slave_mem.sv | 225 ++++++++++++++++++++++
 tb/tb_avmm_slave_mem.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_slave_mem.sv
// Avalon-MM burst slave backed by a DEPTH x DW word store, byte-enabled writes.
// Latency: optional WAIT_CYC stall before accept; first readdatavalid RD_LAT cycles after accept.
// Backpressure: waitrequest stalls commands; held high for a whole read burst; write beats stall on write low.
//
// Ports: clk/rst_n (async active-low); address/read/write/writedata/byteenable/burstcount
// command inputs; waitrequest stall; readdata/readdatavalid read beats; err sticky error.
module avmm_slave_mem #(
    parameter int              AW        = 10,
    parameter int              DW        = 32,
    parameter int              MAX_BURST = 8,
    parameter int              DEPTH     = 256,
    parameter int              WAIT_CYC  = 0,
    parameter int              RD_LAT    = 1,
    parameter logic [DW-1:0]   OOR_DATA  = DW'(32'hDEADBEEF),
    localparam int             BW        = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     address,
    input  logic              read,
    input  logic              write,
    input  logic [DW-1:0]     writedata,
    input  logic [DW/8-1:0]   byteenable,
    input  logic [BW-1:0]     burstcount,
    output logic              waitrequest,
    output logic [DW-1:0]     readdata,
    output logic              readdatavalid,
    output logic              err
);

    localparam int AW1 = AW + 1;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = ($clog2(WAIT_CYC + 1) > 4) ? $clog2(WAIT_CYC + 1) : 4;

    typedef enum logic [2:0] {IDLE, WAIT, WBURST, RLAT, RBURST} state_t;

    logic [DW-1:0] mem [DEPTH];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   len_q, len_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rdv_q, rdv_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            live_q, live_d;

    logic            req;
    logic            bc_over;
    logic [BW-1:0]   bc_len;
    logic            wait_o;
    logic            accept;
    logic [AW1-1:0]  beat_addr;
    logic            beat_oor;
    logic [MW-1:0]   mem_idx;
    logic [DW-1:0]   rd_word;
    logic            beat_we;
    logic            issue;
    logic            mem_we;

    always_comb begin
        req     = read | write;
        bc_over = (burstcount > BW'(MAX_BURST));
        if (burstcount == '0) begin
            bc_len = BW'(1);
        end else if (bc_over) begin
            bc_len = BW'(MAX_BURST);
        end else begin
            bc_len = burstcount;
        end

        // live_q keeps waitrequest high until the first edge after reset release.
        case (state_q)
            IDLE:    wait_o = ~live_q | (WAIT_CYC != 0) | rdv_q;
            WAIT:    wait_o = (cnt_q != '0);
            WBURST:  wait_o = 1'b0;
            default: wait_o = 1'b1;
        endcase

        accept = req & ~wait_o & ((state_q == IDLE) | (state_q == WAIT));

        // At acceptance the beat uses the live address; later beats use latched base + index.
        // One extra bit so that running past 2^AW-1 reads as out of range instead of wrapping.
        beat_addr = accept ? {1'b0, address} : ({1'b0, addr_q} + AW1'(idx_q));
        beat_oor  = (beat_addr >= AW1'(DEPTH));
        mem_idx   = beat_addr[MW-1:0];
        rd_word   = mem[mem_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        addr_d  = addr_q;
        rdv_d   = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        live_d  = 1'b1;
        beat_we = 1'b0;
        issue   = 1'b0;

        case (state_q)
            IDLE: begin
                // The IDLE cycle counts as the first wait cycle, so the counter holds
                // the number of further stall cycles.
                if (!accept && req && live_q && (WAIT_CYC != 0)) begin
                    state_d = WAIT;
                    cnt_d   = CW'(WAIT_CYC - 1);
                end
            end
            WAIT: begin
                if (!accept) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WBURST: begin
                if (write) begin
                    beat_we = 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RLAT: begin
                if (cnt_q <= CW'(1)) begin
                    issue = 1'b1;
                    if (len_q == BW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RBURST;
                        idx_d   = BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RBURST: begin
                issue = 1'b1;
                if (idx_q == len_q - 1'b1) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d = address;
            len_d  = bc_len;
            idx_d  = BW'(1);
            if (bc_over || (read && write)) begin
                err_d = 1'b1;
            end
            if (write) begin
                beat_we = 1'b1;
                state_d = (bc_len == BW'(1)) ? IDLE : WBURST;
            end else if (RD_LAT == 1) begin
                issue   = 1'b1;
                state_d = (bc_len == BW'(1)) ? IDLE : RBURST;
            end else begin
                // Output register adds one cycle, so the latency counter covers RD_LAT-1.
                state_d = RLAT;
                cnt_d   = CW'(RD_LAT - 1);
                idx_d   = '0;
            end
        end

        mem_we = beat_we & ~beat_oor;
        if ((beat_we | issue) & beat_oor) begin
            err_d = 1'b1;
        end
        if (issue) begin
            rdv_d   = 1'b1;
            rdata_d = beat_oor ? OOR_DATA : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    // Storage deliberately has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DW/8; b++) begin
            if (mem_we && byteenable[b]) begin
                mem[mem_idx][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    assign waitrequest   = wait_o;
    assign readdata      = rdata_q;
    assign readdatavalid = rdv_q;
    assign err           = err_q;

endmodule

// File: tb/tb_avmm_slave_mem.sv
module tb_avmm_slave_mem;

    logic        clk;
    logic        rst_n;
    logic [9:0]  address       [2];
    logic        read          [2];
    logic        write         [2];
    logic [31:0] writedata     [2];
    logic [3:0]  byteenable    [2];
    logic [3:0]  burstcount    [2];
    logic        waitrequest   [2];
    logic [31:0] readdata      [2];
    logic        readdatavalid [2];
    logic        err           [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_dat [$];
    int          got_cyc [$];
    logic [31:0] exp_dat [$];
    int          wr_low;

    typedef struct {
        bit          is_wr;
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [3:0]  bc;
    } vec_t;
    vec_t tbl [14];

    // u0: no wait states, read latency 1.  u1: 3 wait states, read latency 3.
    avmm_slave_mem #(.WAIT_CYC(0), .RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .address(address[0]), .read(read[0]), .write(write[0]),
        .writedata(writedata[0]), .byteenable(byteenable[0]), .burstcount(burstcount[0]),
        .waitrequest(waitrequest[0]), .readdata(readdata[0]),
        .readdatavalid(readdatavalid[0]), .err(err[0]));

    avmm_slave_mem #(.WAIT_CYC(3), .RD_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .address(address[1]), .read(read[1]), .write(write[1]),
        .writedata(writedata[1]), .byteenable(byteenable[1]), .burstcount(burstcount[1]),
        .waitrequest(waitrequest[1]), .readdata(readdata[1]),
        .readdatavalid(readdatavalid[1]), .err(err[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_beats(input string nm, input int lat);
        chk({nm, "_nbeats"}, got_dat.size(), exp_dat.size());
        for (int k = 0; k < exp_dat.size(); k++) begin
            if (k < got_dat.size()) begin
                chk($sformatf("%s_dat%0d", nm, k), got_dat[k], exp_dat[k]);
                chk($sformatf("%s_cyc%0d", nm, k), got_cyc[k], lat + k);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_wait%0d", s), waitrequest[s], 1'b1);
            chk($sformatf("rst_rdv%0d", s), readdatavalid[s], 1'b0);
            chk($sformatf("rst_rdata%0d", s), readdata[s], 32'h0);
            chk($sformatf("rst_err%0d", s), err[s], 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_wait0_pre_edge", waitrequest[0], 1'b1);
        @(posedge clk); #1;
        chk("rel_wait0_post_edge", waitrequest[0], 1'b0);
        chk("rel_wait1_post_edge", waitrequest[1], 1'b1);
    endtask

    // Single-beat write; waits out waitrequest, returns 1ns after the accepting edge.
    task automatic wr1(input int s, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        address[s] = a; writedata[s] = d; byteenable[s] = be; burstcount[s] = 4'd1;
        write[s] = 1'b1;
        #1;
        n = 0;
        while (waitrequest[s] !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("wr_accept_timeout", n, 0);
        @(posedge clk); #1;
        write[s] = 1'b0;
        byteenable[s] = 4'h0;
    endtask

    // Read command; collects beats with their cycle index (1 = cycle after accepting edge).
    task automatic rd(input int s, input logic [9:0] a, input logic [3:0] bc);
        int n;
        got_dat.delete();
        got_cyc.delete();
        wr_low = -1;
        address[s] = a; burstcount[s] = bc; read[s] = 1'b1;
        #1;
        n = 0;
        while (waitrequest[s] !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("rd_accept_timeout", n, 0);
        @(posedge clk); #1;
        read[s] = 1'b0;
        address[s] = 10'h0;
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (readdatavalid[s] === 1'b1) begin
                got_dat.push_back(readdata[s]);
                got_cyc.push_back(c);
            end
            if (waitrequest[s] === 1'b0 && wr_low < 0) wr_low = c;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        int hc;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            address[s] = '0; read[s] = 1'b0; write[s] = 1'b0;
            writedata[s] = '0; byteenable[s] = '0; burstcount[s] = '0;
        end

        tbl[0]  = '{1'b1, 10'd5,   32'h12345678, 4'hF, 4'd1};
        tbl[1]  = '{1'b0, 10'd5,   32'h12345678, 4'h0, 4'd1};
        tbl[2]  = '{1'b1, 10'd6,   32'hAABBCCDD, 4'hF, 4'd1};
        tbl[3]  = '{1'b1, 10'd6,   32'h11223344, 4'h5, 4'd1};
        tbl[4]  = '{1'b0, 10'd6,   32'hAA22CC44, 4'h0, 4'd1};
        tbl[5]  = '{1'b1, 10'd7,   32'hFFFFFFFF, 4'hF, 4'd1};
        tbl[6]  = '{1'b1, 10'd7,   32'h00000000, 4'h0, 4'd1};
        tbl[7]  = '{1'b0, 10'd7,   32'hFFFFFFFF, 4'h0, 4'd0};
        tbl[8]  = '{1'b1, 10'd255, 32'hCAFEF00D, 4'hF, 4'd1};
        tbl[9]  = '{1'b0, 10'd255, 32'hCAFEF00D, 4'h0, 4'd1};
        tbl[10] = '{1'b1, 10'd0,   32'h01020304, 4'hF, 4'd1};
        tbl[11] = '{1'b1, 10'd0,   32'h0BADC0DE, 4'hC, 4'd1};
        tbl[12] = '{1'b0, 10'd0,   32'h0BAD0304, 4'h0, 4'd1};
        tbl[13] = '{1'b0, 10'd5,   32'h12345678, 4'h0, 4'd0};

        do_reset();

        // Single-beat write/read vectors on the zero-wait, latency-1 instance.
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].is_wr) begin
                wr1(0, tbl[i].a, tbl[i].d, tbl[i].be);
            end else begin
                rd(0, tbl[i].a, tbl[i].bc);
                exp_dat = '{tbl[i].d};
                chk_beats($sformatf("vec%0d", i), 1);
                chk($sformatf("vec%0d_wait_release", i), wr_low, 2);
                chk($sformatf("vec%0d_err", i), err[0], 1'b0);
            end
        end

        // Wait states: write held high sees exactly three stalled cycles.
        wr1(1, 10'd21, 32'h55555555, 4'hF);
        address[1] = 10'd20; writedata[1] = 32'h13572468; byteenable[1] = 4'hF;
        burstcount[1] = 4'd1; write[1] = 1'b1;
        #1;
        hc = 0;
        while (waitrequest[1] !== 1'b0 && hc < 40) begin
            hc++;
            @(posedge clk); #1;
        end
        chk("wait_cycles", hc, 3);
        @(posedge clk); #1;
        write[1] = 1'b0;
        rd(1, 10'd20, 4'd2);
        exp_dat = '{32'h13572468, 32'h55555555};
        chk_beats("one_write", 3);

        // Burst write of 4 from 10 with a 2-cycle gap and a partial beat 2.
        wr1(1, 10'd12, 32'hFFFFFFFF, 4'hF);
        wr1(1, 10'd14, 32'h77777777, 4'hF);
        address[1] = 10'd10; burstcount[1] = 4'd4; writedata[1] = 32'h10101010;
        byteenable[1] = 4'hF; write[1] = 1'b1;
        #1;
        n = 0;
        while (waitrequest[1] !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("wburst_accept_timeout", n, 0);
        @(posedge clk); #1;
        writedata[1] = 32'h20202020;
        #1;
        chk("wburst_wait_low", waitrequest[1], 1'b0);
        @(posedge clk); #1;
        write[1] = 1'b0; address[1] = 10'h3FF; writedata[1] = 32'h99999999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        write[1] = 1'b1; writedata[1] = 32'h3333ABCD; byteenable[1] = 4'h3;
        @(posedge clk); #1;
        writedata[1] = 32'h40404040; byteenable[1] = 4'hF;
        @(posedge clk); #1;
        write[1] = 1'b0;
        rd(1, 10'd10, 4'd5);
        exp_dat = '{32'h10101010, 32'h20202020, 32'hFFFFABCD, 32'h40404040, 32'h77777777};
        chk_beats("wburst", 3);
        chk("wburst_err", err[1], 1'b0);

        // Burst crossing DEPTH, then one running past 2^AW-1.
        wr1(0, 10'd254, 32'hA5A5A5A5, 4'hF);
        chk("cross_err_before", err[0], 1'b0);
        rd(0, 10'd254, 4'd4);
        exp_dat = '{32'hA5A5A5A5, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF};
        chk_beats("cross", 1);
        chk("cross_wait_release", wr_low, 5);
        chk("cross_err_after", err[0], 1'b1);
        rd(0, 10'd1022, 4'd4);
        exp_dat = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        chk_beats("nowrap", 1);

        // burstcount above MAX_BURST is clamped to 8 beats.
        wr1(1, 10'd37, 32'h37373737, 4'hF);
        chk("clamp_err_before", err[1], 1'b0);
        rd(1, 10'd30, 4'd12);
        chk("clamp_nbeats", got_dat.size(), 8);
        if (got_dat.size() >= 8) begin
            chk("clamp_first_cyc", got_cyc[0], 3);
            chk("clamp_last_dat", got_dat[7], 32'h37373737);
        end
        chk("clamp_err_after", err[1], 1'b1);

        do_reset();

        // read and write together is a write.
        read[0] = 1'b1;
        wr1(0, 10'd40, 32'hFACEB00C, 4'hF);
        read[0] = 1'b0;
        chk("rw_err", err[0], 1'b1);
        rd(0, 10'd40, 4'd1);
        exp_dat = '{32'hFACEB00C};
        chk_beats("rw_data", 1);

        // Reset during beat 2 of an 8-beat read.
        address[0] = 10'd0; burstcount[0] = 4'd8; read[0] = 1'b1;
        #1;
        n = 0;
        while (waitrequest[0] !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("abort_accept_timeout", n, 0);
        @(posedge clk); #1;
        read[0] = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(posedge clk); #1;
        end
        #1;
        chk("abort_rdv_before", readdatavalid[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_rdv_drop", readdatavalid[0], 1'b0);
        chk("abort_wait_high", waitrequest[0], 1'b1);
        chk("abort_rdata_zero", readdata[0], 32'h0);
        chk("abort_err_clear", err[0], 1'b0);
        @(posedge clk); #1;
        chk("abort_wait_held", waitrequest[0], 1'b1);
        chk("abort_rdv_held", readdatavalid[0], 1'b0);
        rst_n = 1'b1;
        rd(0, 10'd5, 4'd1);
        exp_dat = '{32'h12345678};
        chk_beats("post_rst5", 1);
        rd(0, 10'd0, 4'd1);
        exp_dat = '{32'h0BAD0304};
        chk_beats("post_rst0", 1);
        rd(1, 10'd12, 4'd1);
        exp_dat = '{32'hFFFFABCD};
        chk_beats("post_rst_u1", 3);
        chk("post_rst_err", err[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
